// File: rtl/mult_ctrl_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier.
// Combinational only: no latency, no flow control.
package mult_ctrl_pkg;

  localparam int OP_W   = 8;
  localparam int NIB_W  = 4;
  localparam int PP_W   = 8;
  localparam int RES_W  = 16;
  localparam int MODE_W = 4;
  localparam int CNT_W  = 8;

  // Partial-product shift amounts, in issue order LL, LH, HL, HH
  localparam int SH_LL = 0;
  localparam int SH_LH = 4;
  localparam int SH_HL = 4;
  localparam int SH_HH = 8;

  localparam int MODE_LL = 0;
  localparam int MODE_LH = 1;
  localparam int MODE_HL = 2;
  localparam int MODE_HH = 3;

  typedef enum logic [2:0] {
    IDLE,
    MUL0,
    MUL1,
    MUL2,
    MUL3,
    DONE
  } state_t;

endpackage

// File: rtl/mult_8x8_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequential multiplier.
// No logic: latency and backpressure are owned by the endpoints.
interface mult_8x8_seq_ctrl_if;
  import mult_ctrl_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   A;
  logic [OP_W-1:0]   B;
  logic [MODE_W-1:0] cfg_mode;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  R;
  logic [CNT_W-1:0]  done_cnt;

  modport master (
    output in_valid, A, B, cfg_mode, out_ready,
    input  in_ready, out_valid, R, done_cnt
  );

  modport slave (
    input  in_valid, A, B, cfg_mode, out_ready,
    output in_ready, out_valid, R, done_cnt
  );

endinterface

// File: rtl/pp_unit_4x4.sv
// 4x4 unsigned product; approx zeroes the two LSBs of the product.
// Purely combinational: zero latency, no backpressure.
module pp_unit_4x4
  import mult_ctrl_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             approx,
  output logic [PP_W-1:0]  pp
);

  always_comb begin
    pp = PP_W'(a) * PP_W'(b);
    if (approx) pp[1:0] = 2'b00;
  end

endmodule

// File: rtl/mult_8x8_seq_ctrl.sv
// Sequential 8x8 multiplier sharing one 4x4 unit over four cycles; result 4 edges after accept.
// Accepts only in IDLE; holds R/out_valid in DONE until out_ready, min issue interval 6 cycles.
module mult_8x8_seq_ctrl
  import mult_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  mult_8x8_seq_ctrl_if.slave  bus
);

  state_t            state_q, state_d;
  logic [OP_W-1:0]   a_q, a_d;
  logic [OP_W-1:0]   b_q, b_d;
  logic [MODE_W-1:0] mode_q, mode_d;
  logic [RES_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic [NIB_W-1:0]  nib_a, nib_b;
  logic              approx;
  logic [3:0]        shamt;
  logic [PP_W-1:0]   pp;
  logic [RES_W-1:0]  pp_sh;

  // Operand nibbles, approximation bit and weight for the current MULn step
  always_comb begin
    nib_a  = a_q[3:0];
    nib_b  = b_q[3:0];
    approx = mode_q[MODE_LL];
    shamt  = 4'(SH_LL);
    case (state_q)
      MUL1: begin
        nib_b  = b_q[7:4];
        approx = mode_q[MODE_LH];
        shamt  = 4'(SH_LH);
      end
      MUL2: begin
        nib_a  = a_q[7:4];
        approx = mode_q[MODE_HL];
        shamt  = 4'(SH_HL);
      end
      MUL3: begin
        nib_a  = a_q[7:4];
        nib_b  = b_q[7:4];
        approx = mode_q[MODE_HH];
        shamt  = 4'(SH_HH);
      end
      default: ;
    endcase
  end

  pp_unit_4x4 u_pp (
    .a      (nib_a),
    .b      (nib_b),
    .approx (approx),
    .pp     (pp)
  );

  assign pp_sh = RES_W'(pp) << shamt;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = MUL0;
          a_d     = bus.A;
          b_d     = bus.B;
          mode_d  = bus.cfg_mode;
          acc_d   = '0;
        end
      end
      MUL0: begin
        acc_d   = acc_q + pp_sh;
        state_d = MUL1;
      end
      MUL1: begin
        acc_d   = acc_q + pp_sh;
        state_d = MUL2;
      end
      MUL2: begin
        acc_d   = acc_q + pp_sh;
        state_d = MUL3;
      end
      MUL3: begin
        acc_d   = acc_q + pp_sh;
        state_d = DONE;
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.R         = acc_q;
  assign bus.done_cnt  = cnt_q;

endmodule

// File: tb/tb_mult_8x8_seq_ctrl.sv
// Randomized bench for mult_8x8_seq_ctrl against an arithmetic reference model.
module tb_mult_8x8_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   total = 0;
  int   bad = 0;

  mult_8x8_seq_ctrl_if bus ();

  mult_8x8_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sum of the four nibble products, each optionally losing its two LSBs
  function automatic logic [15:0] ref_prod(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] m);
    int s;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      int an, bn, p;
      an = (i / 2 == 1) ? int'(a[7:4]) : int'(a[3:0]);
      bn = (i % 2 == 1) ? int'(b[7:4]) : int'(b[3:0]);
      p  = an * bn;
      if (m[i]) p = p - (p % 4);
      s += p << (4 * (i / 2 + i % 2));
    end
    return 16'(s);
  endfunction

  // Model: phase 0 idle, 1..4 computing, 5 result presented
  int         m_phase = 0;
  logic [15:0] m_exp = '0;
  logic [7:0]  m_cnt = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_cnt   = '0;
    end else if (m_phase == 0) begin
      if (bus.in_valid) begin
        m_phase = 1;
        m_exp   = ref_prod(bus.A, bus.B, bus.cfg_mode);
      end
    end else if (m_phase < 5) begin
      m_phase++;
    end else if (bus.out_ready) begin
      m_phase = 0;
      m_cnt++;
    end
  end

  always @(negedge clk) begin
    chk("cmp_in_ready", 32'(bus.in_ready), 32'(m_phase == 0));
    chk("cmp_out_valid", 32'(bus.out_valid), 32'(m_phase == 5));
    chk("cmp_done_cnt", 32'(bus.done_cnt), 32'(m_cnt));
    if (m_phase == 5) chk("cmp_r", 32'(bus.R), 32'(m_exp));
    if (!rst_n) chk("cmp_r_reset", 32'(bus.R), 32'h0);
  end

  task automatic wait_idle();
    for (int k = 0; k < 50 && !bus.in_ready; k++) @(negedge clk);
    if (!bus.in_ready) chk("idle_timeout", 32'(bus.in_ready), 32'h1);
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [3:0] m,
                        input int hold, output logic [15:0] r, output int lat);
    wait_idle();
    bus.A = a; bus.B = b; bus.cfg_mode = m;
    bus.in_valid = 1'b1; bus.out_ready = 1'b0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.A = 8'($urandom); bus.B = 8'($urandom); bus.cfg_mode = 4'($urandom);
    lat = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (bus.out_valid) break;
      @(posedge clk); #1;
      lat++;
    end
    if (!bus.out_valid) chk("result_timeout", 32'(bus.out_valid), 32'h1);
    r = bus.R;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      bus.in_valid = ~bus.in_valid;
      @(negedge clk);
      chk("hold_out_valid", 32'(bus.out_valid), 32'h1);
      chk("hold_r", 32'(bus.R), 32'(r));
      chk("hold_in_ready", 32'(bus.in_ready), 32'h0);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  initial begin
    logic [15:0] r;
    int lat, hs, gap, last;

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.A = '0; bus.B = '0; bus.cfg_mode = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("model_ffff_exact", 32'(ref_prod(8'hFF, 8'hFF, 4'h0)), 32'hFE01);
    chk("model_ffff_approx", 32'(ref_prod(8'hFF, 8'hFF, 4'hF)), 32'hFCE0);
    chk("model_1337_ll", 32'(ref_prod(8'h13, 8'h37, 4'h1)), 32'h0414);

    run_op(8'hFF, 8'hFF, 4'h0, 0, r, lat);
    chk("ffff_exact_r", 32'(r), 32'hFE01);
    chk("ffff_latency", 32'(lat), 32'd4);
    run_op(8'hFF, 8'hFF, 4'hF, 0, r, lat);
    chk("ffff_approx_r", 32'(r), 32'hFCE0);
    run_op(8'h13, 8'h37, 4'h1, 3, r, lat);
    chk("1337_ll_approx_r", 32'(r), 32'h0414);
    run_op(8'h13, 8'h37, 4'h0, 0, r, lat);
    chk("1337_exact_r", 32'(r), 32'h0415);
    chk("done_cnt_after_4", 32'(bus.done_cnt), 32'd4);

    // Reset while the third partial product is being accumulated
    wait_idle();
    bus.A = 8'hA5; bus.B = 8'h5A; bus.cfg_mode = 4'h0; bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'h0);
    chk("rst_r", 32'(bus.R), 32'h0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'h1);
    chk("rst_done_cnt", 32'(bus.done_cnt), 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("no_stale_result", 32'(bus.out_valid), 32'h0);
    end

    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      bus.in_valid  = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      bus.A = 8'($urandom); bus.B = 8'($urandom); bus.cfg_mode = 4'($urandom);
    end

    #1 rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;

    bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    hs = 0; last = 0;
    for (int k = 0; k < 257 * 6 + 40; k++) begin
      @(posedge clk); #1;
      bus.A = 8'($urandom); bus.B = 8'($urandom); bus.cfg_mode = 4'($urandom);
      @(negedge clk);
      if (bus.out_valid) begin
        hs++;
        if (hs > 1) begin
          gap = k - last;
          chk("b2b_issue_interval", 32'(gap), 32'd6);
        end
        last = k;
        if (hs == 257) begin
          bus.in_valid = 1'b0;
          break;
        end
      end
    end
    chk("b2b_handshakes", 32'(hs), 32'd257);
    @(posedge clk); #1;
    chk("b2b_done_cnt_wrap", 32'(bus.done_cnt), 32'd1);
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
